// File: rtl/tick_sequencer_if.sv
// rtl/tick_sequencer_if.sv - control/status bundle between a controller and tick_sequencer
interface tick_sequencer_if #(
    parameter int WIDTH = 8
);
    // Controller-driven requests
    logic             Load;
    logic [WIDTH-1:0] Period;
    logic             Start;
    logic             Stop;
    logic             Mode;

    // Sequencer-driven status
    logic             Tick;
    logic             Busy;
    logic             Done;
    logic [WIDTH-1:0] EventCount;

    modport master (
        output Load, Period, Start, Stop, Mode,
        input  Tick, Busy, Done, EventCount
    );

    modport slave (
        input  Load, Period, Start, Stop, Mode,
        output Tick, Busy, Done, EventCount
    );
endinterface

// File: rtl/tick_sequencer.sv
// rtl/tick_sequencer.sv - programmable one-shot/periodic tick generator with event counter
module tick_sequencer #(
    parameter int WIDTH = 8
) (
    input  logic           Clock,
    input  logic           Clear_b,
    tick_sequencer_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] period_reg;
    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] event_count;
    logic             mode_reg;
    logic             tick_r;

    // A Load in the same cycle as Start supplies the period the new run uses
    logic [WIDTH-1:0] start_period;
    logic             start_ok;

    // Resolve the period a new run would start with and whether it is legal
    always_comb begin
        start_period = period_reg;
        if (bus.Load) begin
            start_period = bus.Period;
        end
        start_ok = bus.Start && (start_period != '0);
    end

    // Sequencer state, down-counter, tick pulse and event counter
    always_ff @(posedge Clock or negedge Clear_b) begin
        if (!Clear_b) begin
            state       <= IDLE;
            period_reg  <= '0;
            count       <= '0;
            mode_reg    <= 1'b0;
            event_count <= '0;
            tick_r      <= 1'b0;
        end else begin
            tick_r <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (bus.Load) begin
                        period_reg <= bus.Period;
                        if (state == DONE) begin
                            state <= IDLE;
                        end
                    end
                    // Stop has no meaning here; a zero period silently refuses to start
                    if (start_ok) begin
                        count       <= start_period - WIDTH'(1);
                        mode_reg    <= bus.Mode;
                        event_count <= '0;
                        state       <= RUN;
                    end
                end

                RUN: begin
                    // Stop beats an expiry in the same cycle, so Count may pause at zero
                    if (bus.Stop) begin
                        state <= PAUSE;
                    end else if (count != '0) begin
                        count <= count - WIDTH'(1);
                    end else begin
                        tick_r      <= 1'b1;
                        event_count <= event_count + WIDTH'(1);
                        if (mode_reg) begin
                            count <= period_reg - WIDTH'(1);
                        end else begin
                            state <= DONE;
                        end
                    end
                end

                PAUSE: begin
                    // Count is held so total RUN time between ticks stays one period
                    if (bus.Stop) begin
                        state <= IDLE;
                        count <= '0;
                    end else if (bus.Start) begin
                        state <= RUN;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.Tick       = tick_r;
    assign bus.Busy       = (state == RUN) || (state == PAUSE);
    assign bus.Done       = (state == DONE);
    assign bus.EventCount = event_count;

endmodule

// File: tb/tb_tick_sequencer.sv
// tb/tb_tick_sequencer.sv - directed self-checking bench for tick_sequencer
module tb_tick_sequencer;

    localparam int WIDTH = 8;

    logic Clock;
    logic Clear_b;

    tick_sequencer_if #(.WIDTH(WIDTH)) bus ();

    tick_sequencer #(.WIDTH(WIDTH)) dut (
        .Clock   (Clock),
        .Clear_b (Clear_b),
        .bus     (bus.slave)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Advance one rising edge, then settle 1 time unit past it
    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic idle_inputs();
        bus.Load   = 1'b0;
        bus.Start  = 1'b0;
        bus.Stop   = 1'b0;
    endtask

    task automatic abort_run();
        idle_inputs();
        bus.Stop = 1'b1;
        step();
        step();
        bus.Stop = 1'b0;
    endtask

    int ticks;

    initial begin
        Clear_b    = 1'b0;
        bus.Load   = 1'b0;
        bus.Period = '0;
        bus.Start  = 1'b0;
        bus.Stop   = 1'b0;
        bus.Mode   = 1'b0;

        // Reset state
        step();
        step();
        check("rst_tick", bus.Tick, 0);
        check("rst_busy", bus.Busy, 0);
        check("rst_done", bus.Done, 0);
        check("rst_ec",   bus.EventCount, 0);
        Clear_b = 1'b1;
        step();

        // Periodic, period 4: ticks after edges 4, 8, 12
        bus.Load = 1'b1; bus.Period = 8'd4;
        step();
        idle_inputs();
        bus.Mode = 1'b1; bus.Start = 1'b1;
        step();
        idle_inputs();
        check("p4_busy", bus.Busy, 1);
        check("p4_done", bus.Done, 0);
        for (int i = 1; i <= 12; i++) begin
            step();
            check($sformatf("p4_tick%0d", i), bus.Tick, (i % 4 == 0) ? 1 : 0);
            if (i % 4 == 0) check($sformatf("p4_ec%0d", i), bus.EventCount, i / 4);
        end
        abort_run();
        check("p4_abort_busy", bus.Busy, 0);

        // One-shot, period 3
        bus.Load = 1'b1; bus.Period = 8'd3;
        step();
        idle_inputs();
        bus.Mode = 1'b0; bus.Start = 1'b1;
        step();
        idle_inputs();
        for (int i = 1; i <= 3; i++) begin
            step();
            check($sformatf("os_tick%0d", i), bus.Tick, (i == 3) ? 1 : 0);
        end
        check("os_done", bus.Done, 1);
        check("os_busy", bus.Busy, 0);
        check("os_ec",   bus.EventCount, 1);
        ticks = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (bus.Tick) ticks++;
        end
        check("os_quiet", ticks, 0);
        bus.Stop = 1'b1;
        step();
        bus.Stop = 1'b0;
        check("os_stop_ignored", bus.Done, 1);
        bus.Start = 1'b1;
        step();
        idle_inputs();
        check("os_rerun_ec", bus.EventCount, 0);
        check("os_rerun_busy", bus.Busy, 1);
        step(); step(); step();
        check("os_rerun_ec1", bus.EventCount, 1);
        check("os_rerun_done", bus.Done, 1);

        // Pause/resume with period 5; Load in DONE returns to IDLE
        bus.Load = 1'b1; bus.Period = 8'd5;
        step();
        idle_inputs();
        check("ld_done_clr", bus.Done, 0);
        bus.Mode = 1'b1; bus.Start = 1'b1;
        step();
        idle_inputs();
        step();
        step();
        bus.Stop = 1'b1;
        step();
        bus.Stop = 1'b0;
        check("pz_busy", bus.Busy, 1);
        ticks = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (bus.Tick) ticks++;
        end
        check("pz_no_tick", ticks, 0);
        bus.Start = 1'b1;
        step();
        idle_inputs();
        step();
        check("pz_r1", bus.Tick, 0);
        step();
        check("pz_r2", bus.Tick, 0);
        step();
        check("pz_r3", bus.Tick, 1);
        check("pz_ec", bus.EventCount, 1);
        bus.Stop = 1'b1;
        step();
        check("pz_pause2", bus.Busy, 1);
        step();
        bus.Stop = 1'b0;
        check("pz_abort", bus.Busy, 0);
        check("pz_ec_kept", bus.EventCount, 1);

        // Period 1 periodic: Tick continuous, EventCount wraps
        bus.Load = 1'b1; bus.Period = 8'd1;
        step();
        idle_inputs();
        bus.Mode = 1'b1; bus.Start = 1'b1;
        step();
        idle_inputs();
        ticks = 0;
        for (int i = 1; i <= 260; i++) begin
            step();
            if (bus.Tick) ticks++;
            if (i == 255) check("p1_ec255", bus.EventCount, 255);
            if (i == 256) check("p1_ec256", bus.EventCount, 0);
        end
        check("p1_ticks", ticks, 260);
        check("p1_ec260", bus.EventCount, 4);
        abort_run();

        // Zero period refused
        bus.Load = 1'b1; bus.Period = 8'd0;
        step();
        idle_inputs();
        bus.Start = 1'b1;
        step();
        step();
        idle_inputs();
        check("z_busy", bus.Busy, 0);
        check("z_tick", bus.Tick, 0);

        // Load+Start together use new period 6; Stop on expiry edge
        bus.Load = 1'b1; bus.Period = 8'd6; bus.Start = 1'b1; bus.Mode = 1'b1;
        step();
        idle_inputs();
        bus.Period = 8'd2;
        check("ls_busy", bus.Busy, 1);
        ticks = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (bus.Tick) ticks++;
        end
        check("ls_pre", ticks, 0);
        bus.Stop = 1'b1;
        step();
        bus.Stop = 1'b0;
        check("se_tick", bus.Tick, 0);
        check("se_busy", bus.Busy, 1);
        step();
        bus.Start = 1'b1;
        step();
        idle_inputs();
        check("se_resume_edge", bus.Tick, 0);
        step();
        check("se_tick_next", bus.Tick, 1);
        check("se_ec", bus.EventCount, 1);
        ticks = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (bus.Tick) ticks++;
        end
        check("p6_gap", ticks, 0);
        step();
        check("p6_tick", bus.Tick, 1);
        abort_run();

        // Asynchronous reset mid-run
        bus.Load = 1'b1; bus.Period = 8'd4;
        step();
        idle_inputs();
        bus.Mode = 1'b1; bus.Start = 1'b1;
        step();
        idle_inputs();
        for (int i = 0; i < 5; i++) step();
        check("ar_pre_busy", bus.Busy, 1);
        check("ar_pre_ec", bus.EventCount, 1);
        #2 Clear_b = 1'b0;
        #1;
        check("ar_busy", bus.Busy, 0);
        check("ar_ec", bus.EventCount, 0);
        check("ar_tick", bus.Tick, 0);
        check("ar_done", bus.Done, 0);
        #1 Clear_b = 1'b1;
        step();
        bus.Start = 1'b1;
        step();
        idle_inputs();
        check("ar_start_ign", bus.Busy, 0);
        ticks = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (bus.Tick) ticks++;
        end
        check("ar_no_tick", ticks, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
